// File: rtl/packet_checker.sv
// packet_checker -- consumer stage for the RDMX test-packet stream.
//
// Accepts 512-bit AXI-Stream beats from the packet generator and checks
// framing (tlast position), the RDMX header (beat 1), the PCI target address
// carried in the header and the 32-bit sequence-counter payload. Results are
// reported as counters plus sticky error flags for the host-side harness.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   start                synchronous pulse clearing all state and expectations
//   axis_tdata/tvalid/tuser/tlast   incoming stream; axis_tready never stalls
//   packets_rcvd         number of tlast beats accepted
//   error_count          beats carrying at least one error (saturating)
//   err_flags            sticky [0]=payload [1]=header [2]=length [3]=tuser
//   first_err_pkt        packets_rcvd value at the first erroring beat
//   pass                 at least one packet seen and no error flags set
//
// rdmx_encoder builds the expected header. Wire byte k of the header sits at
// bits [8k+7:8k] (little-endian beat layout). Header byte stream, MSB first:
//   "RDMX" magic, version 0x01, opcode 0x01, 16-bit reserved,
//   64-bit target address, 32-bit payload length, zero padding.

module rdmx_encoder (
  input  logic [63:0]  target,
  input  logic [31:0]  length,
  output logic [511:0] le_rdmx_header
);

  logic [511:0] be_hdr_s;

  // Assemble the big-endian byte stream, then place byte k at lane k
  always_comb begin
    be_hdr_s       = {32'h5244_4D58, 8'h01, 8'h01, 16'h0000, target, length, 352'h0};
    le_rdmx_header = 512'h0;
    for (int k = 0; k < 64; k++) begin
      le_rdmx_header[8*k +: 8] = be_hdr_s[511 - 8*k -: 8];
    end
  end

endmodule

module packet_checker #(
  parameter int PAYLOAD_SIZE = 4096
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] axis_tdata,
  input  logic         axis_tvalid,
  input  logic         axis_tuser,
  input  logic         axis_tlast,
  output logic         axis_tready,
  output logic [63:0]  packets_rcvd,
  output logic [31:0]  error_count,
  output logic [3:0]   err_flags,
  output logic [63:0]  first_err_pkt,
  output logic         pass
);

  localparam int         LAST_CYCLE = PAYLOAD_SIZE / 64 + 1;
  localparam logic [7:0] LAST_BEAT  = 8'(LAST_CYCLE);
  // First beat past the expected end; flagging only here gives one overrun
  // error per packet however long it runs on.
  localparam logic [7:0] OVER_BEAT  = 8'(LAST_CYCLE + 1);

  logic [7:0]   beat_r;
  logic [31:0]  exp_seq_r;
  logic [31:0]  exp_addr_r;

  logic [511:0] enc_hdr_s;
  logic         xfer_s;
  logic         hdr_beat_s;
  logic         seq_ok_s;
  logic [3:0]   err_vec_s;
  logic [7:0]   beat_nxt_s;
  logic [31:0]  exp_seq_nxt_s;
  logic [31:0]  exp_addr_nxt_s;
  logic [63:0]  pkts_nxt_s;
  logic [31:0]  errs_nxt_s;
  logic [3:0]   flags_nxt_s;
  logic [63:0]  first_nxt_s;

  rdmx_encoder u_enc (
    .target         ({32'h0, exp_addr_r}),
    .length         (32'(PAYLOAD_SIZE)),
    .le_rdmx_header (enc_hdr_s)
  );

  // Per-beat checks on the accepted beat
  always_comb begin
    xfer_s     = axis_tvalid & axis_tready;
    hdr_beat_s = (beat_r == 8'd1);
    seq_ok_s   = (axis_tdata[511:480] == exp_seq_r);
    err_vec_s  = 4'b0000;
    if (xfer_s) begin
      if (hdr_beat_s) begin
        err_vec_s[1] = !seq_ok_s || (axis_tdata[479:0] != enc_hdr_s[479:0]);
        err_vec_s[0] = !seq_ok_s;
      end else begin
        err_vec_s[0] = (axis_tdata != {16{exp_seq_r}});
      end
      if (axis_tlast) begin
        err_vec_s[2] = (beat_r != LAST_BEAT);
      end else begin
        err_vec_s[2] = (beat_r == OVER_BEAT);
      end
      err_vec_s[3] = axis_tlast & axis_tuser;
    end else begin
      err_vec_s = 4'b0000;
    end
  end

  // Next-state for all tracking state; start takes priority over a beat
  always_comb begin
    beat_nxt_s     = beat_r;
    exp_seq_nxt_s  = exp_seq_r;
    exp_addr_nxt_s = exp_addr_r;
    pkts_nxt_s     = packets_rcvd;
    errs_nxt_s     = error_count;
    flags_nxt_s    = err_flags;
    first_nxt_s    = first_err_pkt;
    if (start) begin
      beat_nxt_s     = 8'd1;
      exp_seq_nxt_s  = 32'h0;
      exp_addr_nxt_s = 32'h0;
      pkts_nxt_s     = 64'h0;
      errs_nxt_s     = 32'h0;
      flags_nxt_s    = 4'b0000;
      first_nxt_s    = 64'h0;
    end else if (xfer_s) begin
      // Resync to the received value so one bad beat costs one error
      exp_seq_nxt_s = axis_tdata[511:480] + 32'd1;
      if (axis_tlast) begin
        beat_nxt_s     = 8'd1;
        exp_addr_nxt_s = exp_addr_r + 32'(PAYLOAD_SIZE);
        pkts_nxt_s     = packets_rcvd + 64'd1;
      end else begin
        beat_nxt_s = (beat_r == 8'd255) ? 8'd255 : beat_r + 8'd1;
      end
      if (|err_vec_s) begin
        errs_nxt_s  = (error_count == 32'hFFFF_FFFF) ? error_count : error_count + 32'd1;
        flags_nxt_s = err_flags | err_vec_s;
        if (err_flags == 4'b0000) begin
          first_nxt_s = packets_rcvd;
        end else begin
          first_nxt_s = first_err_pkt;
        end
      end else begin
        errs_nxt_s = error_count;
      end
    end else begin
      beat_nxt_s = beat_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      axis_tready   <= 1'b0;
      beat_r        <= 8'd1;
      exp_seq_r     <= 32'h0;
      exp_addr_r    <= 32'h0;
      packets_rcvd  <= 64'h0;
      error_count   <= 32'h0;
      err_flags     <= 4'b0000;
      first_err_pkt <= 64'h0;
      pass          <= 1'b0;
    end else begin
      axis_tready   <= 1'b1;
      beat_r        <= beat_nxt_s;
      exp_seq_r     <= exp_seq_nxt_s;
      exp_addr_r    <= exp_addr_nxt_s;
      packets_rcvd  <= pkts_nxt_s;
      error_count   <= errs_nxt_s;
      err_flags     <= flags_nxt_s;
      first_err_pkt <= first_nxt_s;
      pass          <= (pkts_nxt_s != 64'h0) && (flags_nxt_s == 4'b0000);
    end
  end

endmodule

// File: tb/tb_packet_checker.sv
// tb_packet_checker -- directed bench for packet_checker.
// A small generator model produces RDMX packets (header + 64 payload beats,
// continuing sequence counter, address stepping by 4096); each scenario
// compares the checker's counters and flags with hand-derived values.

module tb_packet_checker;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [511:0] axis_tdata;
  logic         axis_tvalid;
  logic         axis_tuser;
  logic         axis_tlast;
  logic         axis_tready;
  logic [63:0]  packets_rcvd;
  logic [31:0]  error_count;
  logic [3:0]   err_flags;
  logic [63:0]  first_err_pkt;
  logic         pass;

  int           n_checks;
  int           n_fail;
  logic [31:0]  gen_seq;
  logic [31:0]  gen_addr;

  packet_checker #(.PAYLOAD_SIZE(4096)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .axis_tdata    (axis_tdata),
    .axis_tvalid   (axis_tvalid),
    .axis_tuser    (axis_tuser),
    .axis_tlast    (axis_tlast),
    .axis_tready   (axis_tready),
    .packets_rcvd  (packets_rcvd),
    .error_count   (error_count),
    .err_flags     (err_flags),
    .first_err_pkt (first_err_pkt),
    .pass          (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected header, built byte by byte as the generator lays it on the wire
  function automatic logic [511:0] hdr_model(input logic [31:0] addr);
    logic [7:0]   b [64];
    logic [511:0] h;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    b[0] = 8'h52; b[1] = 8'h44; b[2] = 8'h4D; b[3] = 8'h58;
    b[4] = 8'h01; b[5] = 8'h01;
    b[12] = addr[31:24]; b[13] = addr[23:16]; b[14] = addr[15:8]; b[15] = addr[7:0];
    b[18] = 8'h10;  // length 0x0000_1000
    h = 512'h0;
    for (int i = 0; i < 64; i++) h[8*i +: 8] = b[i];
    return h;
  endfunction

  // Send one packet: nbeats beats, tlast on beat tlast_at (0 = none),
  // xmask XORed into beat xbeat, tuser on the tlast beat, random idle gaps
  task automatic send_pkt(input int nbeats, input int tlast_at, input int xbeat,
                          input logic [511:0] xmask, input logic tuser, input int gap_max);
    logic [511:0] d;
    logic [511:0] h;
    for (int b = 1; b <= nbeats; b++) begin
      for (int g = 0; g < int'($urandom_range(gap_max, 0)); g++) begin
        @(negedge clk);
        axis_tvalid = 1'b0;
      end
      if (b == 1) begin
        h = hdr_model(gen_addr);
        d = {gen_seq, h[479:0]};
      end else begin
        d = {16{gen_seq}};
      end
      if (b == xbeat) d = d ^ xmask;
      gen_seq = gen_seq + 32'd1;
      @(negedge clk);
      axis_tdata  = d;
      axis_tvalid = 1'b1;
      axis_tlast  = (b == tlast_at);
      axis_tuser  = (b == tlast_at) ? tuser : 1'b0;
    end
    @(negedge clk);
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    axis_tuser  = 1'b0;
    if (tlast_at != 0) gen_addr = gen_addr + 32'd4096;
  endtask

  // Start pulse with a coinciding erroneous tlast beat that must be discarded
  task automatic do_start();
    @(negedge clk);
    start       = 1'b1;
    axis_tvalid = 1'b1;
    axis_tlast  = 1'b1;
    axis_tuser  = 1'b1;
    axis_tdata  = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    start       = 1'b0;
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    axis_tuser  = 1'b0;
    gen_seq     = 32'h0;
    gen_addr    = 32'h0;
    check_val("start_pkts", packets_rcvd, 64'd0);
    check_val("start_flags", {60'h0, err_flags}, 64'h0);
  endtask

  task automatic clean_pkt(input int gap_max);
    send_pkt(65, 65, 0, 512'h0, 1'b0, gap_max);
  endtask

  initial begin
    logic [511:0] m;
    n_checks    = 0;
    n_fail      = 0;
    gen_seq     = 32'h0;
    gen_addr    = 32'h0;
    resetn      = 1'b0;
    start       = 1'b0;
    axis_tdata  = 512'h0;
    axis_tvalid = 1'b0;
    axis_tuser  = 1'b0;
    axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tready", {63'h0, axis_tready}, 64'd0);
    check_val("rst_pkts", packets_rcvd, 64'd0);
    check_val("rst_errs", {32'h0, error_count}, 64'd0);
    check_val("rst_pass", {63'h0, pass}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_val("tready_up", {63'h0, axis_tready}, 64'd1);

    // 1: eight clean packets, then a ninth whose header carries 0x8000
    do_start();
    for (int p = 0; p < 8; p++) clean_pkt(0);
    check_val("t1_pkts", packets_rcvd, 64'd8);
    check_val("t1_errs", {32'h0, error_count}, 64'd0);
    check_val("t1_pass", {63'h0, pass}, 64'd1);
    clean_pkt(0);
    check_val("t1_addr8000_pkts", packets_rcvd, 64'd9);
    check_val("t1_addr8000_errs", {32'h0, error_count}, 64'd0);

    // 2: one payload bit flipped in third packet, beat 10
    do_start();
    m = 512'h0; m[5] = 1'b1;
    for (int p = 0; p < 5; p++) begin
      if (p == 2) send_pkt(65, 65, 10, m, 1'b0, 0);
      else clean_pkt(0);
    end
    check_val("t2_errs", {32'h0, error_count}, 64'd1);
    check_val("t2_flags", {60'h0, err_flags}, 64'h1);
    check_val("t2_first", first_err_pkt, 64'd2);
    check_val("t2_pkts", packets_rcvd, 64'd5);
    check_val("t2_pass", {63'h0, pass}, 64'd0);

    // 3: early tlast on beat 64, then a full packet continuing the sequence
    do_start();
    send_pkt(64, 64, 0, 512'h0, 1'b0, 0);
    clean_pkt(0);
    check_val("t3_flags", {60'h0, err_flags}, 64'h4);
    check_val("t3_errs", {32'h0, error_count}, 64'd1);
    check_val("t3_first", first_err_pkt, 64'd0);
    check_val("t3_pkts", packets_rcvd, 64'd2);

    // 4: header address bit 4 corrupted in packet 5 (wire byte 15 = addr LSB)
    do_start();
    m = 512'h0; m[124] = 1'b1;
    for (int p = 0; p < 6; p++) begin
      if (p == 5) send_pkt(65, 65, 1, m, 1'b0, 0);
      else clean_pkt(0);
    end
    check_val("t4_flags", {60'h0, err_flags}, 64'h2);
    check_val("t4_errs", {32'h0, error_count}, 64'd1);
    check_val("t4_first", first_err_pkt, 64'd5);

    // 5: idle gaps between beats, then tuser on a tlast
    do_start();
    for (int p = 0; p < 8; p++) clean_pkt(7);
    check_val("t5_pkts", packets_rcvd, 64'd8);
    check_val("t5_errs", {32'h0, error_count}, 64'd0);
    check_val("t5_pass", {63'h0, pass}, 64'd1);
    send_pkt(65, 65, 0, 512'h0, 1'b1, 3);
    check_val("t5_tuser_flags", {60'h0, err_flags}, 64'h8);
    check_val("t5_tuser_first", first_err_pkt, 64'd8);
    check_val("t5_tuser_pass", {63'h0, pass}, 64'd0);

    // 7: long packet, tlast on beat 70: overrun at 66 plus late tlast = 2 errors
    do_start();
    send_pkt(70, 70, 0, 512'h0, 1'b0, 0);
    check_val("t7_flags", {60'h0, err_flags}, 64'h4);
    check_val("t7_errs", {32'h0, error_count}, 64'd2);
    clean_pkt(0);
    check_val("t7_after_errs", {32'h0, error_count}, 64'd2);

    // 6: reset mid-packet, no start afterwards; next beat must be a header
    do_start();
    clean_pkt(0);
    send_pkt(20, 0, 0, 512'h0, 1'b0, 0);
    check_val("t6_pre_pkts", packets_rcvd, 64'd1);
    resetn = 1'b0;
    #1;
    check_val("t6_async_pkts", packets_rcvd, 64'd0);
    check_val("t6_async_tready", {63'h0, axis_tready}, 64'd0);
    @(negedge clk);
    resetn   = 1'b1;
    gen_seq  = 32'h0;
    gen_addr = 32'h0;
    @(negedge clk);
    clean_pkt(0);
    clean_pkt(2);
    check_val("t6_pkts", packets_rcvd, 64'd2);
    check_val("t6_errs", {32'h0, error_count}, 64'd0);
    check_val("t6_pass", {63'h0, pass}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
